// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with optional early termination.
// Operands are reduced to magnitudes, multiplied one multiplier bit per
// RUN cycle, and the sign is reapplied in a single FIX cycle.
module shift_add_mult #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         signed_mode,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [2*WIDTH-1:0]           p,
  output logic [$clog2(WIDTH+1)-1:0]   iters
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic [2*WIDTH-1:0]   r_p;
  logic [CW-1:0]        r_iters;
  logic [CW-1:0]        w_cnt_nxt;
  logic [WIDTH-1:0]     w_mplier_nxt;
  logic                 w_last;

  // Magnitude in WIDTH unsigned bits; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? ((~v) + ONE_W) : v;
  endfunction

  // Two's-complement negation of the full-width accumulator.
  function automatic logic [2*WIDTH-1:0] f_neg(input logic [2*WIDTH-1:0] v);
    return (~v) + ONE_2W;
  endfunction

  assign w_cnt_nxt    = r_cnt + CNT_ONE;
  assign w_mplier_nxt = r_mplier >> 1;
  assign w_last       = (w_cnt_nxt == CNT_MAX) ||
                        ((EARLY_EXIT != 0) && (w_mplier_nxt == '0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort overrides the normal RUN/FIX progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (abort) w_next = S_IDLE;
               else if (w_last) w_next = S_FIX;
      S_FIX:   w_next = abort ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded purely from the state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_IDLE:  ready = 1'b1;
      S_RUN,
      S_FIX:   busy  = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and sign fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_p      <= '0;
      r_iters  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mcand  <= {{WIDTH{1'b0}}, f_mag(a, signed_mode)};
          r_mplier <= f_mag(b, signed_mode);
          r_sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= w_cnt_nxt;
        end
        S_FIX: if (!abort) begin
          r_p     <= r_sign ? f_neg(r_acc) : r_acc;
          r_iters <= r_cnt;
        end
        default: ;
      endcase
    end
  end

  assign p     = r_p;
  assign iters = r_iters;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=8), one instance with early
// exit and one that always runs the full iteration count.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0;
  logic        start0 = 1'b0;
  logic        abort = 1'b0;
  logic        sm = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        ready1, busy1, done1, ready0, busy0, done0;
  logic [15:0] p1, p0;
  logic [3:0]  it1, it0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  it;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .signed_mode(sm),
    .a(a), .b(b), .ready(ready1), .busy(busy1), .done(done1), .p(p1), .iters(it1)
  );

  shift_add_mult #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .signed_mode(sm),
    .a(a), .b(b), .ready(ready0), .busy(busy0), .done(done0), .p(p0), .iters(it0)
  );

  // Reference: exact product, iteration count and edge latency.
  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_v,
                                 input logic tsm, input bit ee0);
    exp_t e;
    logic signed [15:0] sa, sbv;
    logic [7:0] mb;
    int k;
    if (tsm) begin
      sa  = $signed(ta);
      sbv = $signed(tb_v);
      e.p = sa * sbv;
    end else begin
      e.p = {8'h00, ta} * {8'h00, tb_v};
    end
    mb = (tsm && tb_v[7]) ? 8'(8'h00 - tb_v) : tb_v;
    k = 1;
    for (int i = 0; i < 8; i++) if (mb[i]) k = i + 1;
    if (ee0) k = 8;
    e.it  = 4'(k);
    e.lat = k + 1;
    return e;
  endfunction

  // Drives one operation, queues its expectation and waits (bounded) for done.
  task automatic issue_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsm,
                          input bit ee0, input bit scramble,
                          output logic [15:0] op, output logic [3:0] oit, output int olat);
    @(negedge clk);
    a = ta; b = tb_v; sm = tsm;
    if (ee0) start0 = 1'b1; else start1 = 1'b1;
    exp_q.push_back(model(ta, tb_v, tsm, ee0));
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    olat = -1; op = 'x; oit = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ee0 ? done0 : done1) begin
        olat = n;
        op   = ee0 ? p0 : p1;
        oit  = ee0 ? it0 : it1;
        break;
      end
      if (scramble) begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        sm = 1'($urandom);
        if (ee0) start0 = 1'($urandom); else start1 = 1'($urandom);
      end
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done1); end
    checks++; if (p1 !== 16'h0) begin failures++; $display("FAIL rst_p got=%h exp=0000", p1); end
    checks++; if (it1 !== 4'h0) begin failures++; $display("FAIL rst_iters got=%0d exp=0", it1); end
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL rst_ready_full got=%b exp=1", ready0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta [9] = '{8'd255, 8'd13, 8'd13, 8'h80, 8'hFB, 8'hFB, 8'h55, 8'h80, 8'd6};
    logic [7:0] tb_v [9] = '{8'd255, 8'd3, 8'd3, 8'h80, 8'd7, 8'd7, 8'h00, 8'h80, 8'd7};
    logic       ts [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit         te [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] op; logic [3:0] oit; int olat; exp_t e;
    for (int i = 0; i < 9; i++) begin
      issue_op(ta[i], tb_v[i], ts[i], te[i], 1'b0, op, oit, olat);
      e = exp_q.pop_front();
      checks++; if (op !== e.p) begin failures++; $display("FAIL dir_p[%0d] got=%h exp=%h", i, op, e.p); end
      checks++; if (oit !== e.it) begin failures++; $display("FAIL dir_iters[%0d] got=%0d exp=%0d", i, oit, e.it); end
      checks++; if (olat !== e.lat) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, olat, e.lat); end
      @(negedge clk);
      checks++;
      if ((te[i] ? done0 : done1) !== 1'b0 || (te[i] ? ready0 : ready1) !== 1'b1) begin
        failures++; $display("FAIL dir_pulse[%0d] got done=%b ready=%b exp done=0 ready=1", i,
                             te[i] ? done0 : done1, te[i] ? ready0 : ready1);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] op; logic [3:0] oit; int olat; exp_t e;
    logic [7:0] ra, rb; logic rs; bit re;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); re = 1'($urandom);
      if (i % 6 == 0) rb = 8'($urandom_range(0, 3));
      issue_op(ra, rb, rs, re, 1'b1, op, oit, olat);
      e = exp_q.pop_front();
      checks++; if (op !== e.p) begin failures++; $display("FAIL rnd_p a=%h b=%h s=%0d got=%h exp=%h", ra, rb, rs, op, e.p); end
      checks++; if (oit !== e.it) begin failures++; $display("FAIL rnd_iters a=%h b=%h got=%0d exp=%0d", ra, rb, oit, e.it); end
      checks++; if (olat !== e.lat) begin failures++; $display("FAIL rnd_latency a=%h b=%h got=%0d exp=%0d", ra, rb, olat, e.lat); end
    end
  endtask

  task automatic test_abort();
    logic [15:0] op; logic [3:0] oit; int olat; exp_t e; bit seen;
    issue_op(8'd6, 8'd7, 1'b0, 1'b0, 1'b0, op, oit, olat);
    e = exp_q.pop_front();
    checks++; if (op !== e.p) begin failures++; $display("FAIL abort_pre_p got=%h exp=%h", op, e.p); end
    @(negedge clk);
    a = 8'd9; b = 8'd9; sm = 1'b0; start1 = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL abort_idle_busy got=%b exp=1", busy1); end
    abort = 1'b0; start1 = 1'b0; a = 8'h77;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b1; b = 8'hFF; sm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready1); end
    checks++; if (p1 !== 16'd42) begin failures++; $display("FAIL abort_p got=%0d exp=42", p1); end
    checks++; if (it1 !== 4'd3) begin failures++; $display("FAIL abort_iters got=%0d exp=3", it1); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done1 !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin failures++; $display("FAIL abort_no_done got=done_seen exp=no_done"); end
  endtask

  task automatic test_async_reset();
    logic [15:0] op; logic [3:0] oit; int olat; exp_t e; bit seen;
    @(negedge clk);
    a = 8'd200; b = 8'd201; sm = 1'b0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", ready1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy1); end
    checks++; if (p1 !== 16'h0) begin failures++; $display("FAIL arst_p got=%h exp=0000", p1); end
    checks++; if (it1 !== 4'h0) begin failures++; $display("FAIL arst_iters got=%0d exp=0", it1); end
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL arst_no_done got=done_seen exp=no_done"); end
    issue_op(8'hC3, 8'h2D, 1'b1, 1'b0, 1'b0, op, oit, olat);
    e = exp_q.pop_front();
    checks++; if (op !== e.p) begin failures++; $display("FAIL arst_after_p got=%h exp=%h", op, e.p); end
    checks++; if (oit !== e.it) begin failures++; $display("FAIL arst_after_iters got=%0d exp=%0d", oit, e.it); end
    checks++; if (olat !== e.lat) begin failures++; $display("FAIL arst_after_latency got=%0d exp=%0d", olat, e.lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
